// File: rtl/instruction_sequencer.sv
// Tensor-core instruction sequencer: loadable instruction memory, FETCH/EXEC/ISSUE FSM.
// Optional single-level hardware loop instruction is enabled by defining SEQ_LOOP_EN.
module instruction_sequencer #(
    parameter int INSTR_WIDTH = 32,
    parameter int IMEM_DEPTH  = 64,
    parameter int ADDR_WIDTH  = $clog2(IMEM_DEPTH)
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic                   load_valid_in,
    input  logic [ADDR_WIDTH-1:0]  load_addr_in,
    input  logic [INSTR_WIDTH-1:0] load_data_in,
    input  logic                   start_in,
    output logic                   issue_valid_out,
    output logic [INSTR_WIDTH-1:0] issue_instr_out,
    input  logic                   issue_ready_in,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   error_out
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0]            OP_NOP  = 4'h0;
    localparam logic [3:0]            OP_LOOP = 4'hE;
    localparam logic [3:0]            OP_HALT = 4'hF;
    localparam logic [ADDR_WIDTH-1:0] PC_LAST = ADDR_WIDTH'(IMEM_DEPTH - 1);

    logic [INSTR_WIDTH-1:0] mem_r [IMEM_DEPTH];
    logic [INSTR_WIDTH-1:0] rd_data_r;
    state_t                 state_r;
    logic [ADDR_WIDTH-1:0]  pc_r;
    logic                   issue_valid_r;
    logic [INSTR_WIDTH-1:0] issue_instr_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   error_r;
    logic [3:0]             opcode_s;
    logic                   advance_s;
    logic                   pc_last_s;

`ifdef SEQ_LOOP_EN
    logic                   loop_active_r;
    logic [7:0]             loop_rem_r;
    logic [7:0]             loop_count_s;
    logic [ADDR_WIDTH-1:0]  loop_target_s;

    assign loop_count_s  = rd_data_r[27:20];
    assign loop_target_s = rd_data_r[ADDR_WIDTH-1:0];
`endif

    assign issue_valid_out = issue_valid_r;
    assign issue_instr_out = issue_instr_r;
    assign pc_out          = pc_r;
    assign busy_out        = busy_r;
    assign done_out        = done_r;
    assign error_out       = error_r;

    // Instruction memory: load writes only while idle, registered read at pc (not reset).
    always_ff @(posedge clock_in) begin
        if (load_valid_in && (state_r == ST_IDLE)) begin
            mem_r[load_addr_in] <= load_data_in;
        end
        rd_data_r <= mem_r[pc_r];
    end

    // Decide whether this cycle wants pc+1 (sequential flow out of EXEC or ISSUE).
    always_comb begin
        opcode_s  = rd_data_r[INSTR_WIDTH-1 -: 4];
        pc_last_s = (pc_r == PC_LAST);
        advance_s = 1'b0;
        case (state_r)
            ST_EXEC: begin
                if (opcode_s == OP_NOP) begin
                    advance_s = 1'b1;
`ifdef SEQ_LOOP_EN
                end else if (opcode_s == OP_LOOP) begin
                    advance_s = loop_active_r ? (loop_rem_r == 8'd0) : (loop_count_s == 8'd0);
`endif
                end else begin
                    advance_s = 1'b0;
                end
            end
            ST_ISSUE: advance_s = issue_ready_in;
            default:  advance_s = 1'b0;
        endcase
    end

    // Sequencer FSM with registered outputs; a pc step past the last word ends in error.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_r       <= ST_IDLE;
            pc_r          <= '0;
            issue_valid_r <= 1'b0;
            issue_instr_r <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
`ifdef SEQ_LOOP_EN
            loop_active_r <= 1'b0;
            loop_rem_r    <= 8'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_in) begin
                        state_r <= ST_FETCH;
                        pc_r    <= '0;
                        error_r <= 1'b0;
                        busy_r  <= 1'b1;
`ifdef SEQ_LOOP_EN
                        loop_active_r <= 1'b0;
                        loop_rem_r    <= 8'd0;
`endif
                    end
                end
                ST_FETCH: state_r <= ST_EXEC;
                ST_EXEC: begin
                    case (opcode_s)
                        OP_NOP: begin
                        end
                        OP_HALT: begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end
                        OP_LOOP: begin
`ifdef SEQ_LOOP_EN
                            if (advance_s) begin
                                loop_active_r <= 1'b0;
                            end else begin
                                pc_r    <= loop_target_s;
                                state_r <= ST_FETCH;
                                if (loop_active_r) begin
                                    loop_rem_r <= loop_rem_r - 8'd1;
                                end else begin
                                    loop_active_r <= 1'b1;
                                    loop_rem_r    <= loop_count_s - 8'd1;
                                end
                            end
`else
                            error_r <= 1'b1;
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
`endif
                        end
                        default: begin
                            state_r       <= ST_ISSUE;
                            issue_valid_r <= 1'b1;
                            issue_instr_r <= rd_data_r;
                        end
                    endcase
                end
                ST_ISSUE: begin
                    if (issue_ready_in) begin
                        issue_valid_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase

            if (advance_s) begin
                if (pc_last_s) begin
                    error_r <= 1'b1;
                    done_r  <= 1'b1;
                    state_r <= ST_DONE;
                end else begin
                    pc_r    <= pc_r + ADDR_WIDTH'(1);
                    state_r <= ST_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed self-checking bench for instruction_sequencer (default depth 64, 32-bit words).
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    logic        load_valid_in = 1'b0;
    logic [5:0]  load_addr_in = 6'd0;
    logic [31:0] load_data_in = 32'd0;
    logic        start_in = 1'b0;
    logic        issue_ready_in = 1'b1;
    logic        issue_valid_out;
    logic [31:0] issue_instr_out;
    logic [5:0]  pc_out;
    logic        busy_out;
    logic        done_out;
    logic        error_out;

    int          n_assert = 0;
    int          n_fail = 0;
    int          n_iss;
    logic [31:0] iss_instr [80];
    int          iss_cyc [80];
    bit          got_done;
    logic        done_err;
    logic [5:0]  done_pc;

    instruction_sequencer dut (
        .clock_in        (clk),
        .reset_in        (reset_in),
        .load_valid_in   (load_valid_in),
        .load_addr_in    (load_addr_in),
        .load_data_in    (load_data_in),
        .start_in        (start_in),
        .issue_valid_out (issue_valid_out),
        .issue_instr_out (issue_instr_out),
        .issue_ready_in  (issue_ready_in),
        .pc_out          (pc_out),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .error_out       (error_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [5:0] addr, input logic [31:0] data);
        load_valid_in = 1'b1;
        load_addr_in  = addr;
        load_data_in  = data;
        tick();
        load_valid_in = 1'b0;
    endtask

    task automatic start_prog();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    // Record handshakes and the done pulse; ends one cycle after done is seen.
    task automatic observe(input int max_cyc);
        n_iss = 0;
        got_done = 1'b0;
        done_err = 1'b0;
        done_pc = 6'd0;
        for (int c = 0; c < max_cyc && !got_done; c++) begin
            if (issue_valid_out && issue_ready_in) begin
                if (n_iss < 80) begin
                    iss_instr[n_iss] = issue_instr_out;
                    iss_cyc[n_iss]   = c;
                end
                n_iss++;
            end
            if (done_out) begin
                got_done = 1'b1;
                done_err = error_out;
                done_pc  = pc_out;
            end
            tick();
        end
    endtask

    task automatic check_basic(input string tag);
        chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
        chk({tag, "_n_issue"}, 32'(n_iss), 32'd2);
        chk({tag, "_instr0"}, iss_instr[0], 32'h1000_0001);
        chk({tag, "_instr1"}, iss_instr[1], 32'h2000_0002);
        chk({tag, "_interval"}, 32'(iss_cyc[1] - iss_cyc[0]), 32'd3);
        chk({tag, "_error"}, 32'(done_err), 32'd0);
        chk({tag, "_done_pulse"}, 32'(done_out), 32'd0);
        chk({tag, "_busy_idle"}, 32'(busy_out), 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 10 && !issue_valid_out; i++) tick();
        chk(tag, 32'(issue_valid_out), 32'd1);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_valid", 32'(issue_valid_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        chk("rst_error", 32'(error_out), 32'd0);
        chk("rst_pc", 32'(pc_out), 32'd0);
        reset_in = 1'b0;
        tick();

        // Basic program; last word loaded in the same cycle as start
        load(6'd0, 32'h1000_0001);
        load(6'd1, 32'h2000_0002);
        load_valid_in = 1'b1;
        load_addr_in  = 6'd2;
        load_data_in  = 32'hF000_0000;
        start_in      = 1'b1;
        tick();
        load_valid_in = 1'b0;
        start_in      = 1'b0;
        chk("basic_busy", 32'(busy_out), 32'd1);
        observe(100);
        check_basic("basic");

        // Back-pressure: ready low for 5 cycles on the first issue
        issue_ready_in = 1'b0;
        start_prog();
        wait_valid("stall_wait");
        for (int k = 0; k < 6; k++) begin
            if (k == 5) issue_ready_in = 1'b1;
            chk($sformatf("stall_valid_%0d", k), 32'(issue_valid_out), 32'd1);
            chk($sformatf("stall_instr_%0d", k), issue_instr_out, 32'h1000_0001);
            chk($sformatf("stall_pc_%0d", k), 32'(pc_out), 32'd0);
            tick();
        end
        chk("stall_pc_after", 32'(pc_out), 32'd1);
        chk("stall_valid_after", 32'(issue_valid_out), 32'd0);
        observe(100);
        chk("stall_done_seen", 32'(got_done), 32'd1);
        chk("stall_n_issue", 32'(n_iss), 32'd1);
        chk("stall_instr1", iss_instr[0], 32'h2000_0002);

        // Loop program: body at 0, loop count 3 to target 0, halt
        load(6'd0, 32'h1000_0000);
        load(6'd1, 32'hE030_0000);
        load(6'd2, 32'hF000_0000);
        start_prog();
        observe(200);
        chk("loop_done_seen", 32'(got_done), 32'd1);
`ifdef SEQ_LOOP_EN
        chk("loop_n_issue", 32'(n_iss), 32'd4);
        chk("loop_error", 32'(done_err), 32'd0);
        chk("loop_pc", 32'(done_pc), 32'd2);
`else
        chk("loop_n_issue", 32'(n_iss), 32'd1);
        chk("loop_error", 32'(done_err), 32'd1);
        chk("loop_pc", 32'(done_pc), 32'd1);
`endif
        chk("loop_instr0", iss_instr[0], 32'h1000_0000);

        // Run off the end of memory
        for (int a = 0; a < 64; a++) load(6'(a), 32'h1000_0000);
        start_prog();
        observe(400);
        chk("ovf_done_seen", 32'(got_done), 32'd1);
        chk("ovf_n_issue", 32'(n_iss), 32'd64);
        chk("ovf_error", 32'(done_err), 32'd1);
        chk("ovf_pc", 32'(done_pc), 32'd63);
        chk("ovf_last_interval", 32'(iss_cyc[63] - iss_cyc[62]), 32'd3);
        chk("ovf_error_sticky", 32'(error_out), 32'd1);

        // Reset during a stalled issue, then restart without reloading
        load(6'd0, 32'h1000_0001);
        load(6'd1, 32'h2000_0002);
        load(6'd2, 32'hF000_0000);
        issue_ready_in = 1'b0;
        start_prog();
        chk("rst2_error_cleared", 32'(error_out), 32'd0);
        wait_valid("rst2_wait");
        reset_in = 1'b1;
        tick();
        chk("rst2_valid", 32'(issue_valid_out), 32'd0);
        chk("rst2_busy", 32'(busy_out), 32'd0);
        chk("rst2_pc", 32'(pc_out), 32'd0);
        chk("rst2_done", 32'(done_out), 32'd0);
        reset_in = 1'b0;
        issue_ready_in = 1'b1;
        tick();
        start_prog();
        observe(100);
        check_basic("restart");

        // Load attempted while busy must be ignored
        start_prog();
        load(6'd0, 32'hF000_0000);
        observe(100);
        check_basic("busyload_run1");
        start_prog();
        observe(100);
        check_basic("busyload_run2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
